// File: rtl/mix_shift_unit.sv
// MIX shift unit (SLA/SRA/SLAX/SRAX/SLC/SRC): one-cycle registered byte shifter
// over rA or the concatenated rAX. Signs are handled outside this block.
module mix_shift_unit #(
  parameter int unsigned BYTE = 6,
  parameter int unsigned WORD = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD-1:0]   ina,
  input  logic [WORD-1:0]   inx,
  input  logic [5:0]        field,
  input  logic [11:0]       m,
  output logic [2*WORD-1:0] out,
  output logic              done
);

  localparam int unsigned DWORD = 2 * WORD;

  logic [DWORD-1:0]   r_out;
  logic               r_done;

  logic [DWORD-1:0]   w_ax;
  logic [3:0]         w_lin;
  logic [3:0]         w_rot;
  logic [6:0]         w_lin_bits;
  logic [6:0]         w_rot_bits;
  logic               w_a_live;
  logic               w_ax_live;
  logic [2*DWORD-1:0] w_dbl_l;
  logic [2*DWORD-1:0] w_dbl_r;
  logic [DWORD-1:0]   w_next;

  assign w_ax      = {ina, inx};
  assign w_a_live  = (m < 12'd5);
  assign w_ax_live = (m < 12'd10);

  // Linear shifts only need the low count when it is in range; larger counts zero the result.
  assign w_lin      = w_ax_live ? m[3:0] : 4'd0;
  assign w_rot      = 4'(m % 12'd10);
  assign w_lin_bits = 7'(w_lin) * 7'(BYTE);
  assign w_rot_bits = 7'(w_rot) * 7'(BYTE);

  // Rotation by shifting a doubled copy and taking the appropriate half.
  assign w_dbl_l = {w_ax, w_ax} << w_rot_bits;
  assign w_dbl_r = {w_ax, w_ax} >> w_rot_bits;

  always_comb begin
    w_next = w_ax;
    case (field)
      6'd0: w_next = {(w_a_live ? (ina << w_lin_bits) : {WORD{1'b0}}), inx};
      6'd1: w_next = {(w_a_live ? (ina >> w_lin_bits) : {WORD{1'b0}}), inx};
      6'd2: w_next = w_ax_live ? (w_ax << w_lin_bits) : {DWORD{1'b0}};
      6'd3: w_next = w_ax_live ? (w_ax >> w_lin_bits) : {DWORD{1'b0}};
      6'd4: w_next = w_dbl_l[2*DWORD-1:DWORD];
      6'd5: w_next = w_dbl_r[DWORD-1:0];
      default: w_next = w_ax;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= start;
      if (start) begin
        r_out <= w_next;
      end
    end
  end

  assign out  = r_out;
  assign done = r_done;

endmodule

// File: tb/tb_mix_shift_unit.sv
// Self-checking bench for mix_shift_unit: directed vector table, handshake and reset
// sequences, and randomized traffic against a byte-array reference model.
module tb_mix_shift_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [29:0] ina = '0;
  logic [29:0] inx = '0;
  logic [5:0]  field = '0;
  logic [11:0] m = '0;
  logic [59:0] out;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_shift_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ina   (ina),
    .inx   (inx),
    .field (field),
    .m     (m),
    .out   (out),
    .done  (done)
  );

  localparam logic [29:0] CA = 30'o0102030405;
  localparam logic [29:0] CX = 30'o0607101112;

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [11:0] mm;
    logic [59:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [59:0] got, input logic [59:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %o expected %o", name, got, exp);
    end
  endtask

  // Reference: treat {A,X} as ten bytes, byte index 0 = A.byte1, and move them by index.
  function automatic logic [59:0] model(input logic [5:0] f, input logic [11:0] mm,
                                        input logic [29:0] a, input logic [29:0] x);
    logic [59:0] ax;
    logic [59:0] r;
    int b[10];
    int nb[10];
    int cnt;
    int src;
    ax  = {a, x};
    cnt = int'(mm);
    for (int i = 0; i < 10; i++) begin
      b[i]  = int'(ax[59-6*i -: 6]);
      nb[i] = b[i];
    end
    for (int i = 0; i < 10; i++) begin
      case (f)
        6'd0: if (i < 5) nb[i] = (i + cnt < 5) ? b[i+cnt] : 0;
        6'd1: if (i < 5) nb[i] = (i - cnt >= 0) ? b[i-cnt] : 0;
        6'd2: nb[i] = (i + cnt < 10) ? b[i+cnt] : 0;
        6'd3: nb[i] = (i - cnt >= 0) ? b[i-cnt] : 0;
        6'd4: nb[i] = b[(i + cnt) % 10];
        6'd5: begin
          src   = (i - (cnt % 10) + 10) % 10;
          nb[i] = b[src];
        end
        default: nb[i] = b[i];
      endcase
    end
    r = '0;
    for (int i = 0; i < 10; i++) r[59-6*i -: 6] = 6'(nb[i]);
    return r;
  endfunction

  task automatic step(input logic s, input logic [5:0] f, input logic [11:0] mm,
                      input logic [29:0] a, input logic [29:0] x);
    @(negedge clk);
    start = s;
    field = f;
    m     = mm;
    ina   = a;
    inx   = x;
    @(posedge clk);
    #1;
  endtask

  logic [59:0] exp_out;
  logic        s_r;
  logic [5:0]  f_r;
  logic [11:0] m_r;
  logic [29:0] a_r;
  logic [29:0] x_r;

  initial begin
    vecs[0] = '{"sla_m1",     6'd0, 12'd1,    60'o02030405000607101112};
    vecs[1] = '{"srax_m3",    6'd3, 12'd3,    60'o00000001020304050607};
    vecs[2] = '{"slc_m12",    6'd4, 12'd12,   60'o03040506071011120102};
    vecs[3] = '{"src_m4091",  6'd5, 12'd4091, 60'o12010203040506071011};
    vecs[4] = '{"slax_m10",   6'd2, 12'd10,   60'o00000000000000000000};
    vecs[5] = '{"sra_m4095",  6'd1, 12'd4095, 60'o00000000000607101112};
    vecs[6] = '{"sla_m0",     6'd0, 12'd0,    60'o01020304050607101112};
    vecs[7] = '{"sra_m2",     6'd1, 12'd2,    60'o00000102030607101112};
    vecs[8] = '{"slax_m4",    6'd2, 12'd4,    60'o05060710111200000000};
    vecs[9] = '{"undef_f6",   6'd6, 12'd3,    60'o01020304050607101112};

    #1;
    chk("reset_out", out, 60'd0);
    chk("reset_done", {59'd0, done}, 60'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].f, vecs[i].mm, CA, CX);
      chk(vecs[i].name, out, vecs[i].exp);
      chk({vecs[i].name, "_done"}, {59'd0, done}, 60'd1);
    end
    step(1'b0, 6'd0, 12'd1, CA, CX);
    chk("idle_hold", out, 60'o01020304050607101112);
    chk("idle_done", {59'd0, done}, 60'd0);

    // Handshake: SLC every other cycle with an incrementing count.
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 6'd4, 12'(k), CA, CX);
      exp_out = model(6'd4, 12'(k), CA, CX);
      chk("hs_result", out, exp_out);
      chk("hs_done", {59'd0, done}, 60'd1);
      step(1'b0, 6'd4, 12'(k + 100), ~CA, CX);
      chk("hs_hold", out, exp_out);
      chk("hs_idle", {59'd0, done}, 60'd0);
    end

    // Randomized traffic against the byte model.
    for (int k = 0; k < 300; k++) begin
      s_r = 1'($urandom_range(0, 3) != 0);
      f_r = 6'($urandom_range(0, 7));
      m_r = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 12)) : 12'($urandom);
      a_r = 30'($urandom);
      x_r = 30'($urandom);
      step(s_r, f_r, m_r, a_r, x_r);
      if (s_r) exp_out = model(f_r, m_r, a_r, x_r);
      chk($sformatf("rnd f=%0d m=%0d", f_r, m_r), out, exp_out);
      chk("rnd_done", {59'd0, done}, {59'd0, s_r});
    end

    // Asynchronous reset mid-run, with a start held across the reset edge.
    step(1'b1, 6'd4, 12'd7, CA, CX);
    chk("pre_rst", out, model(6'd4, 12'd7, CA, CX));
    @(negedge clk);
    start = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 60'd0);
    chk("async_rst_done", {59'd0, done}, 60'd0);
    @(posedge clk);
    #1;
    chk("in_rst_out", out, 60'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_out", out, 60'd0);
    chk("post_rst_done", {59'd0, done}, 60'd0);
    step(1'b1, 6'd5, 12'd1, CA, CX);
    chk("resume", out, 60'o12010203040506071011);
    step(1'b0, 6'd0, 12'd0, CA, CX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
